// File: rtl/lfsr_share_ctrl_if.sv
// Requester and LFSR-side signals of the shared-LFSR scheduler.
// The slave modport is the controller; master is the requesters plus the LFSR.
interface lfsr_share_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8
);
    logic             req_a;
    logic [WIDTH-1:0] seed_a;
    logic [LEN_W-1:0] len_a;
    logic             req_b;
    logic [WIDTH-1:0] seed_b;
    logic [LEN_W-1:0] len_b;
    logic             lfsr_sel;
    logic [WIDTH-1:0] lfsr_init;
    logic [WIDTH-1:0] lfsr_y;
    logic             busy;
    logic             own_a;
    logic             own_b;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             done_a;
    logic             done_b;

    modport master (
        output req_a, seed_a, len_a, req_b, seed_b, len_b, lfsr_y,
        input  lfsr_sel, lfsr_init, busy, own_a, own_b, out_valid, out_data, out_id,
        input  done_a, done_b
    );

    modport slave (
        input  req_a, seed_a, len_a, req_b, seed_b, len_b, lfsr_y,
        output lfsr_sel, lfsr_init, busy, own_a, own_b, out_valid, out_data, out_id,
        output done_a, done_b
    );
endinterface

// File: rtl/lfsr_share_ctrl.sv
// Round-robin scheduler sharing one external LFSR between requesters A and B:
// load the owner's seed, run len steps, stream each state tagged with the owner id.
module lfsr_share_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    lfsr_share_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;  // 1: B wins a tie
    logic             id_q, id_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_id_q, out_id_d;
    logic             grant_b;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        id_d        = id_q;
        seed_d      = seed_q;
        len_d       = len_q;
        count_d     = count_q;
        grant_b     = 1'b0;
        out_valid_d = (state_q == StRun);
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_a || bus.req_b) begin
                    grant_b = bus.req_b && (!bus.req_a || prio_q);
                    id_d    = grant_b;
                    prio_d  = !grant_b;
                    seed_d  = grant_b ? bus.seed_b : bus.seed_a;
                    len_d   = grant_b ? bus.len_b : bus.len_a;
                    state_d = ((grant_b ? bus.len_b : bus.len_a) == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                count_d = len_q;
                state_d = StRun;
            end
            StRun: begin
                out_data_d = bus.lfsr_y;
                out_id_d   = id_q;
                count_d    = count_q - 1'b1;
                if (count_q == LEN_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            id_q        <= 1'b0;
            seed_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            id_q        <= id_d;
            seed_q      <= seed_d;
            len_q       <= len_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign bus.lfsr_sel  = (state_q == StLoad);
    assign bus.lfsr_init = seed_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.own_a     = (state_q != StIdle) && !id_q;
    assign bus.own_b     = (state_q != StIdle) && id_q;
    assign bus.done_a    = (state_q == StDone) && !id_q;
    assign bus.done_b    = (state_q == StDone) && id_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Scoreboard bench for lfsr_share_ctrl: stimulus pushes expected samples and done events,
// a negedge monitor pops and compares them; an 8-bit Fibonacci LFSR stands in for the instance.
module tb_lfsr_share_ctrl;

    typedef struct {
        logic       id;
        logic [7:0] data;
    } samp_t;

    logic       clock;
    logic       reset;
    logic [7:0] lfsr_q = 8'h01;
    int         checks = 0;
    int         errors = 0;
    samp_t      exp_q[$];
    logic [1:0] done_q[$];  // {out_valid expected with done, owner id}

    lfsr_share_ctrl_if #(.WIDTH(8), .LEN_W(8)) bus ();

    lfsr_share_ctrl #(.WIDTH(8), .LEN_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] y);
        return {y[6:0], y[7] ^ y[5] ^ y[4] ^ y[3]};
    endfunction

    // External LFSR: sel loads initial_state, otherwise it advances every cycle.
    always @(posedge clock) lfsr_q <= bus.lfsr_sel ? bus.lfsr_init : lfsr_step(lfsr_q);
    assign bus.lfsr_y = lfsr_q;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_samp(input logic id, input logic [7:0] data);
        samp_t s;
        s.id   = id;
        s.data = data;
        exp_q.push_back(s);
    endtask

    task automatic push_burst(input logic id, input logic [7:0] seed, input int len);
        logic [7:0] s;
        s = seed;
        for (int i = 0; i < len; i++) begin
            push_samp(id, s);
            s = lfsr_step(s);
        end
        done_q.push_back({len != 0, id});
    endtask

    // Monitor: compares every presented sample and done pulse against the scoreboard.
    always @(negedge clock) begin
        samp_t      e;
        logic [1:0] d;
        if (!reset) begin
            chk("own_exclusive", {31'b0, bus.own_a && bus.own_b}, 32'd0);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sample_unexpected", {24'b0, bus.out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample_data", {24'b0, bus.out_data}, {24'b0, e.data});
                    chk("sample_id", {31'b0, bus.out_id}, {31'b0, e.id});
                end
            end
            if (bus.done_a || bus.done_b) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", {30'b0, bus.done_b, bus.done_a}, 32'd0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_owner", {30'b0, bus.done_b, bus.done_a}, d[0] ? 32'd2 : 32'd1);
                    chk("done_last_valid", {31'b0, bus.out_valid}, {31'b0, d[1]});
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, "_sel"}, {31'b0, bus.lfsr_sel}, 32'd0);
        chk({tag, "_init"}, {24'b0, bus.lfsr_init}, 32'd0);
        chk({tag, "_own"}, {30'b0, bus.own_b, bus.own_a}, 32'd0);
        chk({tag, "_done"}, {30'b0, bus.done_b, bus.done_a}, 32'd0);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, "_data"}, {24'b0, bus.out_data}, 32'd0);
        chk({tag, "_id"}, {31'b0, bus.out_id}, 32'd0);
    endtask

    // Asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        reset      = 1'b1;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1;
        check_zero_outputs("reset");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(bus.done_a || bus.done_b) && n < max_cycles);
        chk("done_seen", {31'b0, bus.done_a || bus.done_b}, 32'd1);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_samples_left"}, exp_q.size(), 32'd0);
        chk({tag, "_dones_left"}, done_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        bus.req_a  = 1'b0;
        bus.seed_a = 8'h00;
        bus.len_a  = 8'h00;
        bus.req_b  = 1'b0;
        bus.seed_b = 8'h00;
        bus.len_b  = 8'h00;
        #3;
        do_reset();

        // Single A burst, seed 01 len 4; samples hand-stepped through the LFSR.
        push_samp(1'b0, 8'h01);
        push_samp(1'b0, 8'h02);
        push_samp(1'b0, 8'h04);
        push_samp(1'b0, 8'h08);
        done_q.push_back(2'b10);
        bus.req_a  = 1'b1;
        bus.seed_a = 8'h01;
        bus.len_a  = 8'd4;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) bus.req_a = 1'b0;
            chk("t1_sel", {31'b0, bus.lfsr_sel}, {31'b0, k == 1});
            chk("t1_busy", {31'b0, bus.busy}, {31'b0, k >= 1 && k <= 6});
            chk("t1_done_a", {31'b0, bus.done_a}, {31'b0, k == 6});
            chk("t1_valid", {31'b0, bus.out_valid}, {31'b0, k >= 3 && k <= 6});
        end
        check_drained("t1");

        // Simultaneous requests from reset: A first, B in the IDLE cycle after done_a.
        next_cyc();
        do_reset();
        push_burst(1'b0, 8'h3C, 2);
        push_burst(1'b1, 8'hC3, 2);
        bus.req_a  = 1'b1;
        bus.seed_a = 8'h3C;
        bus.len_a  = 8'd2;
        bus.req_b  = 1'b1;
        bus.seed_b = 8'hC3;
        bus.len_b  = 8'd2;
        wait_done(20);
        chk("t2_first_owner", {31'b0, bus.done_a}, 32'd1);
        @(negedge clock);
        chk("t2_idle_gap", {31'b0, bus.busy}, 32'd0);
        bus.req_a = 1'b0;
        @(negedge clock);
        chk("t2_own_b", {30'b0, bus.own_b, bus.own_a}, 32'd2);
        chk("t2_load_b", {31'b0, bus.lfsr_sel}, 32'd1);
        bus.req_b = 1'b0;
        wait_done(20);
        repeat (3) @(negedge clock);
        check_drained("t2");

        // Both held with len 1: four transactions alternate A,B,A,B.
        next_cyc();
        do_reset();
        push_burst(1'b0, 8'h55, 1);
        push_burst(1'b1, 8'hAA, 1);
        push_burst(1'b0, 8'h55, 1);
        push_burst(1'b1, 8'hAA, 1);
        bus.req_a  = 1'b1;
        bus.seed_a = 8'h55;
        bus.len_a  = 8'd1;
        bus.req_b  = 1'b1;
        bus.seed_b = 8'hAA;
        bus.len_b  = 8'd1;
        for (int t = 0; t < 4; t++) wait_done(20);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        repeat (4) @(negedge clock);
        check_drained("t3");

        // Zero-length request from B: straight to DONE, no load, no samples.
        next_cyc();
        do_reset();
        done_q.push_back(2'b01);
        bus.req_b  = 1'b1;
        bus.seed_b = 8'h99;
        bus.len_b  = 8'd0;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clock);
            if (k == 1) bus.req_b = 1'b0;
            chk("t4_sel", {31'b0, bus.lfsr_sel}, 32'd0);
            chk("t4_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("t4_busy", {31'b0, bus.busy}, {31'b0, k == 1});
            chk("t4_done_b", {31'b0, bus.done_b}, {31'b0, k == 1});
        end
        check_drained("t4");

        // Async reset in the third RUN cycle of a len 10 burst, then a clean A burst.
        next_cyc();
        do_reset();
        push_burst(1'b0, 8'h77, 10);
        bus.req_a  = 1'b1;
        bus.seed_a = 8'h77;
        bus.len_a  = 8'd10;
        next_cyc();
        bus.req_a = 1'b0;
        next_cyc();
        next_cyc();
        next_cyc();
        #2;
        do_reset();
        push_burst(1'b0, 8'h12, 3);
        bus.req_a  = 1'b1;
        bus.seed_a = 8'h12;
        bus.len_a  = 8'd3;
        next_cyc();
        bus.req_a = 1'b0;
        wait_done(20);
        repeat (3) @(negedge clock);
        check_drained("t5");

        // Maximum length burst: 255 samples, first one is the seed A5.
        next_cyc();
        do_reset();
        push_samp(1'b1, 8'hA5);
        push_burst(1'b1, lfsr_step(8'hA5), 254);
        bus.req_b  = 1'b1;
        bus.seed_b = 8'hA5;
        bus.len_b  = 8'hFF;
        next_cyc();
        bus.req_b = 1'b0;
        wait_done(300);
        repeat (3) @(negedge clock);
        check_drained("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
